// File: rtl/register_bus_datapath_pkg.sv
// Shared constants for the register / common-bus datapath: default widths,
// common-bus source selects and ALU operation codes.
package register_bus_datapath_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;

   // Common-bus source selects
   localparam logic [2:0] BUS_ZERO = 3'b000;
   localparam logic [2:0] BUS_AR   = 3'b001;
   localparam logic [2:0] BUS_PC   = 3'b010;
   localparam logic [2:0] BUS_DR   = 3'b011;
   localparam logic [2:0] BUS_AC   = 3'b100;
   localparam logic [2:0] BUS_IR   = 3'b101;
   localparam logic [2:0] BUS_TR   = 3'b110;
   localparam logic [2:0] BUS_MEM  = 3'b111;

   // ALU operations (operand A = AC, operand B = DR)
   localparam logic [2:0] ALU_AND     = 3'b000;
   localparam logic [2:0] ALU_ADD     = 3'b001;
   localparam logic [2:0] ALU_SUB     = 3'b010;
   localparam logic [2:0] ALU_OR      = 3'b011;
   localparam logic [2:0] ALU_XOR     = 3'b100;
   localparam logic [2:0] ALU_PASS_AC = 3'b101;
   localparam logic [2:0] ALU_PASS_DR = 3'b110;
   localparam logic [2:0] ALU_NOT     = 3'b111;

endpackage

// File: rtl/register_bus_datapath_dp_register.sv
// Generic datapath register with synchronous clear, load and increment.
// Priority is clear > load > inc; increment wraps modulo 2^WIDTH.
module dp_register #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic             inc_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next-state selection with clear > load > inc priority
   always_comb begin
      // NOTE: default assignment first so no path leaves q_d unassigned (no latch).
      q_d = q_q;
      if (clear_i)
         q_d = '0;
      else if (load_i)
         q_d = data_i;
      else if (inc_i)
         q_d = q_q + WIDTH'(1);
   end

   // State register, cleared asynchronously by reset
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      if (reset)
         q_q <= '0;
      else
         q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/register_bus_datapath.sv
// Register and common-bus datapath: AR, PC, DR, AC, IR, TR, an 8-way common
// bus and a latched ALU. AC loads from the ALU result latch, not the bus.
// Build option: define ALU_FLAGS_EN to build the carry/zero flag registers;
// without it alu_carry and alu_zero are tied to 0.
module register_bus_datapath
   import register_bus_datapath_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_AR,
   input  logic              load_PC,
   input  logic              load_DR,
   input  logic              load_AC,
   input  logic              load_IR,
   input  logic              load_TR,
   input  logic              clear_AR,
   input  logic              clear_PC,
   input  logic              clear_DR,
   input  logic              clear_AC,
   input  logic              clear_TR,
   input  logic              inc_AR,
   input  logic              inc_PC,
   input  logic              inc_DR,
   input  logic              inc_AC,
   input  logic              inc_TR,
   input  logic [2:0]        bus_selectors,
   input  logic              alu_enable,
   input  logic [2:0]        alu_mode,
   input  logic              memory_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic [DATA_W-1:0] IR,
   output logic [DATA_W-1:0] ac_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              alu_carry,
   output logic              alu_zero
);

   logic [DATA_W-1:0] bus;
   logic [ADDR_W-1:0] ar_q, pc_q;
   logic [DATA_W-1:0] dr_q, ac_q, tr_q, ir_q;
   logic [DATA_W-1:0] alu_result_d, alu_result_q;

   // Common-bus source multiplexer; address registers are zero-extended
   always_comb begin
      bus = '0;
      unique case (bus_selectors)
         BUS_ZERO: bus = '0;
         BUS_AR:   bus = DATA_W'(ar_q);
         BUS_PC:   bus = DATA_W'(pc_q);
         BUS_DR:   bus = dr_q;
         BUS_AC:   bus = ac_q;
         BUS_IR:   bus = ir_q;
         BUS_TR:   bus = tr_q;
         BUS_MEM:  bus = mem_rdata;
      endcase
   end

   dp_register #(.WIDTH(ADDR_W)) u_ar (
      .clock(clock), .reset(reset), .clear_i(clear_AR), .load_i(load_AR),
      .inc_i(inc_AR), .data_i(bus[ADDR_W-1:0]), .q_o(ar_q));

   dp_register #(.WIDTH(ADDR_W)) u_pc (
      .clock(clock), .reset(reset), .clear_i(clear_PC), .load_i(load_PC),
      .inc_i(inc_PC), .data_i(bus[ADDR_W-1:0]), .q_o(pc_q));

   dp_register #(.WIDTH(DATA_W)) u_dr (
      .clock(clock), .reset(reset), .clear_i(clear_DR), .load_i(load_DR),
      .inc_i(inc_DR), .data_i(bus), .q_o(dr_q));

   dp_register #(.WIDTH(DATA_W)) u_ac (
      .clock(clock), .reset(reset), .clear_i(clear_AC), .load_i(load_AC),
      .inc_i(inc_AC), .data_i(alu_result_q), .q_o(ac_q));

   dp_register #(.WIDTH(DATA_W)) u_tr (
      .clock(clock), .reset(reset), .clear_i(clear_TR), .load_i(load_TR),
      .inc_i(inc_TR), .data_i(bus), .q_o(tr_q));

   // Instruction register: load only, no clear or increment
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         ir_q <= '0;
      else if (load_IR)
         ir_q <= bus;
   end

   // ALU datapath result for the current mode
   always_comb begin
      alu_result_d = '0;
      unique case (alu_mode)
         ALU_AND:     alu_result_d = ac_q & dr_q;
         ALU_ADD:     alu_result_d = ac_q + dr_q;
         ALU_SUB:     alu_result_d = ac_q - dr_q;
         ALU_OR:      alu_result_d = ac_q | dr_q;
         ALU_XOR:     alu_result_d = ac_q ^ dr_q;
         ALU_PASS_AC: alu_result_d = ac_q;
         ALU_PASS_DR: alu_result_d = dr_q;
         ALU_NOT:     alu_result_d = ~ac_q;
      endcase
   end

   // ALU result latch, updated only on alu_enable
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         alu_result_q <= '0;
      else if (alu_enable)
         alu_result_q <= alu_result_d;
   end

`ifdef ALU_FLAGS_EN
   logic alu_carry_d, alu_carry_q, alu_zero_q;

   // Carry per mode: add overflow, subtract no-borrow, zero for logic/pass
   always_comb begin
      alu_carry_d = 1'b0;
      if (alu_mode == ALU_ADD)
         alu_carry_d = (ac_q > ~dr_q);   // ac + dr exceeds all-ones
      else if (alu_mode == ALU_SUB)
         alu_carry_d = (ac_q >= dr_q);
   end

   // Flag registers, updated together with the result latch
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         alu_carry_q <= 1'b0;
         alu_zero_q  <= 1'b0;
      end else if (alu_enable) begin
         alu_carry_q <= alu_carry_d;
         alu_zero_q  <= (alu_result_d == '0);
      end
   end

   assign alu_carry = alu_carry_q;
   assign alu_zero  = alu_zero_q;
`else
   assign alu_carry = 1'b0;
   assign alu_zero  = 1'b0;
`endif

   assign mem_addr  = ar_q;
   assign mem_wdata = bus;
   assign mem_we    = memory_write;
   assign IR        = ir_q;
   assign ac_out    = ac_q;
   assign pc_out    = pc_q;

endmodule

// File: tb/tb_register_bus_datapath.sv
// Self-checking bench for register_bus_datapath (default 8-bit widths).
// Directed scenarios followed by randomized strobes, all compared against a
// behavioural model of the register file, bus and ALU.
module tb_register_bus_datapath;

   logic       clock = 1'b0;
   logic       reset;
   logic       load_AR, load_PC, load_DR, load_AC, load_IR, load_TR;
   logic       clear_AR, clear_PC, clear_DR, clear_AC, clear_TR;
   logic       inc_AR, inc_PC, inc_DR, inc_AC, inc_TR;
   logic [2:0] bus_selectors;
   logic       alu_enable;
   logic [2:0] alu_mode;
   logic       memory_write;
   logic [7:0] mem_rdata;
   logic [7:0] mem_addr, mem_wdata, IR, ac_out, pc_out;
   logic       mem_we, alu_carry, alu_zero;

   register_bus_datapath dut (
      .clock(clock), .reset(reset),
      .load_AR(load_AR), .load_PC(load_PC), .load_DR(load_DR),
      .load_AC(load_AC), .load_IR(load_IR), .load_TR(load_TR),
      .clear_AR(clear_AR), .clear_PC(clear_PC), .clear_DR(clear_DR),
      .clear_AC(clear_AC), .clear_TR(clear_TR),
      .inc_AR(inc_AR), .inc_PC(inc_PC), .inc_DR(inc_DR),
      .inc_AC(inc_AC), .inc_TR(inc_TR),
      .bus_selectors(bus_selectors), .alu_enable(alu_enable),
      .alu_mode(alu_mode), .memory_write(memory_write),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .IR(IR), .ac_out(ac_out), .pc_out(pc_out),
      .alu_carry(alu_carry), .alu_zero(alu_zero));

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: the architectural registers, kept as plain integers
   int m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_lat;
   bit m_c, m_z;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int bus_model(input int sel);
      case (sel)
         1: return m_ar;
         2: return m_pc;
         3: return m_dr;
         4: return m_ac;
         5: return m_ir;
         6: return m_tr;
         7: return int'(mem_rdata);
         default: return 0;
      endcase
   endfunction

   function automatic int next_reg(input int old, input bit clr, input bit ld,
                                   input bit inc, input int src);
      if (clr) return 0;
      if (ld)  return src;
      if (inc) return (old + 1) % 256;
      return old;
   endfunction

   task automatic model_reset();
      m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_tr = 0; m_lat = 0;
      m_c = 0; m_z = 0;
   endtask

   // Advance the model across one clock edge using pre-edge values
   task automatic model_edge();
      int b, r, n_ar, n_pc, n_dr, n_ac, n_tr;
      bit c;
      b = bus_model(int'(bus_selectors));
      c = 0;
      case (alu_mode)
         3'd0: r = m_ac & m_dr;
         3'd1: begin r = (m_ac + m_dr) % 256; c = (m_ac + m_dr) > 255; end
         3'd2: begin r = (m_ac - m_dr + 256) % 256; c = m_ac >= m_dr; end
         3'd3: r = m_ac | m_dr;
         3'd4: r = m_ac ^ m_dr;
         3'd5: r = m_ac;
         3'd6: r = m_dr;
         default: r = 255 - m_ac;
      endcase
      n_ar = next_reg(m_ar, clear_AR, load_AR, inc_AR, b);
      n_pc = next_reg(m_pc, clear_PC, load_PC, inc_PC, b);
      n_dr = next_reg(m_dr, clear_DR, load_DR, inc_DR, b);
      n_ac = next_reg(m_ac, clear_AC, load_AC, inc_AC, m_lat);
      n_tr = next_reg(m_tr, clear_TR, load_TR, inc_TR, b);
      if (load_IR) m_ir = b;
      if (alu_enable) begin
         m_lat = r;
`ifdef ALU_FLAGS_EN
         m_c = c;
         m_z = (r == 0);
`endif
      end
      m_ar = n_ar; m_pc = n_pc; m_dr = n_dr; m_ac = n_ac; m_tr = n_tr;
   endtask

   task automatic idle_inputs();
      {load_AR, load_PC, load_DR, load_AC, load_IR, load_TR} = '0;
      {clear_AR, clear_PC, clear_DR, clear_AC, clear_TR} = '0;
      {inc_AR, inc_PC, inc_DR, inc_AC, inc_TR} = '0;
      bus_selectors = 3'd0;
      alu_enable = 1'b0;
      alu_mode = 3'd0;
      memory_write = 1'b0;
      mem_rdata = 8'h00;
   endtask

   // Apply the currently driven inputs for one cycle and check both the
   // combinational outputs before the edge and the registers after it
   task automatic cycle(input string tag);
      #1;
      check({tag, ".mem_we"}, 32'(mem_we), 32'(memory_write));
      check({tag, ".mem_wdata"}, 32'(mem_wdata), bus_model(int'(bus_selectors)));
      check({tag, ".mem_addr_pre"}, 32'(mem_addr), m_ar);
      @(posedge clock);
      model_edge();
      #1;
      check({tag, ".ar"}, 32'(mem_addr), m_ar);
      check({tag, ".pc"}, 32'(pc_out), m_pc);
      check({tag, ".ac"}, 32'(ac_out), m_ac);
      check({tag, ".ir"}, 32'(IR), m_ir);
      check({tag, ".carry"}, 32'(alu_carry), 32'(m_c));
      check({tag, ".zero"}, 32'(alu_zero), 32'(m_z));
      idle_inputs();
   endtask

   task automatic load_from_mem(input logic [7:0] v, input int which);
      mem_rdata = v;
      bus_selectors = 3'b111;
      case (which)
         0: load_AR = 1'b1;
         1: load_PC = 1'b1;
         2: load_DR = 1'b1;
         3: load_TR = 1'b1;
         default: load_IR = 1'b1;
      endcase
      cycle("mem_load");
   endtask

   // Put v into AC through DR, the pass-DR ALU mode and the result latch
   task automatic set_ac(input logic [7:0] v);
      load_from_mem(v, 2);
      alu_mode = 3'b110; alu_enable = 1'b1;
      cycle("set_ac_alu");
      load_AC = 1'b1;
      cycle("set_ac_load");
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      model_reset();
      #12;
      check("reset_ac", 32'(ac_out), 0);
      check("reset_pc", 32'(pc_out), 0);
      reset = 1'b0;
      @(posedge clock); #1;

      // PC on the bus, AR takes old PC while PC increments
      load_from_mem(8'h05, 1);
      bus_selectors = 3'b010; load_AR = 1'b1; inc_PC = 1'b1;
      cycle("self_xfer");
      check("self_xfer_ar", 32'(mem_addr), 32'h05);
      check("self_xfer_pc", 32'(pc_out), 32'h06);

      // DR load from memory, then clear beats load
      load_from_mem(8'h9A, 2);
      bus_selectors = 3'b011;
      #1 check("dr_load", 32'(mem_wdata), 32'h9A);
      mem_rdata = 8'h9A; bus_selectors = 3'b111; load_DR = 1'b1; clear_DR = 1'b1;
      cycle("dr_clear");
      bus_selectors = 3'b011;
      #1 check("dr_cleared", 32'(mem_wdata), 32'h00);

      // ADD with carry out, then ADD producing zero
      set_ac(8'hF0);
      load_from_mem(8'h20, 2);
      alu_mode = 3'b001; alu_enable = 1'b1;
      cycle("add1_alu");
      load_AC = 1'b1;
      cycle("add1_load");
      check("add1_ac", 32'(ac_out), 32'h10);
`ifdef ALU_FLAGS_EN
      check("add1_carry", 32'(alu_carry), 1);
`else
      check("add1_carry", 32'(alu_carry), 0);
`endif
      check("add1_zero", 32'(alu_zero), 0);
      set_ac(8'hF0);
      load_from_mem(8'h10, 2);
      alu_mode = 3'b001; alu_enable = 1'b1;
      cycle("add2_alu");
      load_AC = 1'b1;
      cycle("add2_load");
      check("add2_ac", 32'(ac_out), 32'h00);
`ifdef ALU_FLAGS_EN
      check("add2_zero", 32'(alu_zero), 1);
`else
      check("add2_zero", 32'(alu_zero), 0);
`endif

      // Increment wrap on PC and TR
      load_from_mem(8'hFF, 1);
      inc_PC = 1'b1;
      cycle("pc_wrap");
      check("pc_wrap_val", 32'(pc_out), 32'h00);
      load_from_mem(8'hFF, 3);
      inc_TR = 1'b1;
      cycle("tr_wrap");
      bus_selectors = 3'b110;
      #1 check("tr_wrap_val", 32'(mem_wdata), 32'h00);

      // Memory write of AC: combinational outputs, no register change
      set_ac(8'h3C);
      bus_selectors = 3'b100; memory_write = 1'b1;
      #1;
      check("mw_we", 32'(mem_we), 1);
      check("mw_wdata", 32'(mem_wdata), 32'h3C);
      cycle("mem_write");

      // Randomized strobes against the model
      for (int i = 0; i < 400; i++) begin
         load_AR = ($urandom_range(0, 3) == 0); load_PC = ($urandom_range(0, 3) == 0);
         load_DR = ($urandom_range(0, 3) == 0); load_AC = ($urandom_range(0, 3) == 0);
         load_IR = ($urandom_range(0, 3) == 0); load_TR = ($urandom_range(0, 3) == 0);
         clear_AR = ($urandom_range(0, 7) == 0); clear_PC = ($urandom_range(0, 7) == 0);
         clear_DR = ($urandom_range(0, 7) == 0); clear_AC = ($urandom_range(0, 7) == 0);
         clear_TR = ($urandom_range(0, 7) == 0);
         inc_AR = ($urandom_range(0, 2) == 0); inc_PC = ($urandom_range(0, 2) == 0);
         inc_DR = ($urandom_range(0, 2) == 0); inc_AC = ($urandom_range(0, 2) == 0);
         inc_TR = ($urandom_range(0, 2) == 0);
         bus_selectors = 3'($urandom_range(0, 7));
         alu_enable = ($urandom_range(0, 1) == 0);
         alu_mode = 3'($urandom_range(0, 7));
         memory_write = ($urandom_range(0, 1) == 0);
         mem_rdata = 8'($urandom);
         cycle("rand");
      end

      // Asynchronous reset with non-zero state, checked before any edge
      load_from_mem(8'hA5, 0);
      load_from_mem(8'h5A, 1);
      load_from_mem(8'h77, 3);
      load_from_mem(8'h81, 4);
      set_ac(8'hC3);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_ar", 32'(mem_addr), 0);
      check("rst_pc", 32'(pc_out), 0);
      check("rst_ac", 32'(ac_out), 0);
      check("rst_ir", 32'(IR), 0);
      check("rst_carry", 32'(alu_carry), 0);
      check("rst_zero", 32'(alu_zero), 0);
      bus_selectors = 3'b011;
      #1 check("rst_dr", 32'(mem_wdata), 0);
      bus_selectors = 3'b110;
      #1 check("rst_tr", 32'(mem_wdata), 0);
      @(posedge clock); #2;
      reset = 1'b0;
      idle_inputs();
      @(posedge clock); #1;
      load_AC = 1'b1;
      cycle("rst_latch");
      check("rst_latch_ac", 32'(ac_out), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/register_bus_datapath.md
Name: register_bus_datapath

Overview:
- Register and common-bus datapath, directly downstream of the control unit; consumes its per-cycle load/clear/inc strobes, bus_selectors, alu_enable/alu_mode and memory_write.
- Holds AR, PC, DR, AC, IR and TR, plus an 8-way common bus and a latched ALU with flags.
- Drives the external memory address, write data and write enable, and returns IR to the control unit.

Parameters:
- DATA_W, 8, width of DR, AC, IR, TR, bus and memory data.
- ADDR_W, 8, width of AR and PC; must be ≤ DATA_W.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- load_AR, load_PC, load_DR, load_AC, load_IR, load_TR  in  1 each  load strobes
- clear_AR, clear_PC, clear_DR, clear_AC, clear_TR  in  1 each  synchronous clear strobes
- inc_AR, inc_PC, inc_DR, inc_AC, inc_TR  in  1 each  increment strobes
- bus_selectors  in  3  common-bus source select
- alu_enable  in  1  latch ALU result and flags this edge
- alu_mode  in  3  ALU operation
- memory_write  in  1  write request from the control unit
- mem_rdata  in  DATA_W  memory read data
- mem_addr  out  ADDR_W  equals AR
- mem_wdata  out  DATA_W  equals current bus value
- mem_we  out  1  equals memory_write (combinational pass-through)
- IR  out  DATA_W  instruction register, to the control unit
- ac_out  out  DATA_W  AC value
- pc_out  out  ADDR_W  PC value
- alu_carry, alu_zero  out  1 each  latched flags

Behaviour:
- Reset (async): AR, PC, DR, AC, IR, TR, the ALU result latch and both flags all go to 0 immediately. Reset mid-instruction discards all state; there is no partial completion.
- Bus selection (combinational):
  - 000 → zero
  - 001 → AR (zero-extended)
  - 010 → PC (zero-extended)
  - 011 → DR
  - 100 → AC
  - 101 → IR
  - 110 → TR
  - 111 → mem_rdata
- Register update at posedge: priority is clear > load > inc.
  - Load takes the bus value; AR and PC take bus[ADDR_W-1:0].
  - inc wraps modulo 2^width (e.g. 0xFF+1 = 0x00); no flag is affected.
- IR has no clear or inc; load_IR only.
- AC load source is the ALU result latch, not the bus.
- Self-transfer: the bus samples pre-edge values. PC on the bus with load_AR and inc_PC in the same cycle gives AR = old PC and PC = old PC+1.
- ALU (operand A = AC, B = DR): when alu_enable=1, on the next edge the latch takes the result, and alu_carry/alu_zero update. Otherwise the latch and flags hold.
  - 000 AND
  - 001 ADD: carry = bit DATA_W of the sum
  - 010 SUB (AC-DR): carry = no-borrow
  - 011 OR
  - 100 XOR
  - 101 pass AC (store)
  - 110 pass DR (load)
  - 111 NOT AC
  - Logic and pass modes clear carry.
  - zero = (result == 0).
- Latency: alu_enable at step N → result in latch after edge N → load_AC at step N+1 → AC valid after edge N+1.
- Multiple strobes targeting different registers in one cycle are all honoured independently.
- clear_AC together with alu_enable: AC clears; the latch still updates.
- mem_we and mem_wdata are purely combinational; the memory samples them on the same edge.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: alu_carry and alu_zero are latched as described above.
- Undefined: no flag registers are built; alu_carry and alu_zero are tied to 0. The result latch and AC behaviour are unchanged.

Decomposition:
- Shared package:
  - bus-select constants (BUS_ZERO … BUS_MEM)
  - ALU mode constants (ALU_AND … ALU_NOT)
  - the DATA_W and ADDR_W defaults
- Sub-module dp_register: a parameterised-width register with clear/load/inc and the priority above. It is instantiated for AR, PC, DR, AC and TR. The ALU, the bus mux and IR stay in the top module.

Test Plan:
- Reset with all registers non-zero → all outputs 0 within the same cycle, before any clock edge.
- PC=0x05, bus_selectors=010, load_AR=1, inc_PC=1 → after the edge AR=0x05, PC=0x06, mem_addr=0x05.
- mem_rdata=0x9A, bus_selectors=111, load_DR=1 → DR=0x9A. Repeat with clear_DR=1 as well → DR=0x00.
- AC=0xF0, DR=0x20, alu_mode=001, alu_enable=1, then load_AC=1 → AC=0x10, carry=1, zero=0. Repeat with DR=0x10 → AC=0x00, zero=1.
- PC=0xFF, inc_PC → PC=0x00. TR=0xFF, inc_TR → TR=0x00.
- AC=0x3C, bus_selectors=100, memory_write=1 → mem_we=1 and mem_wdata=0x3C in the same cycle; no register changes.
